// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and sizing helpers for the multi-cycle pipeline hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    // One spare bit so the wait counter can hold MEM_TIMEOUT-1 for any legal MEM_TIMEOUT.
    function automatic int waitCntW(input int memTimeout);
        return $clog2(memTimeout) + 1;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Hazard unit bundle: datapath/controller side is master, hazard unit is slave.
interface hazard_unit_mc_if #(
    parameter int AW = 4
);
    logic [AW-1:0] RA1D, RA2D, RA1E, RA2E;
    logic [AW-1:0] WA3E, WA3M, WA3W;
    logic          RegWriteM, RegWriteW, MemtoRegE;
    logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic          BranchTakenE, MulStartE;
    logic          MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushM, FlushW;
    logic          MulBusy, MemTimeout;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW,
               BranchTakenE, MulStartE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, MulBusy, MemTimeout
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW,
               BranchTakenE, MulStartE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, MulBusy, MemTimeout
    );
endinterface

// File: rtl/hazard_unit_mc_fwd_sel.sv
// Single-operand forwarding select: M beats W, PC register is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW     = 4,
    parameter int PC_REG = 15
) (
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] wa3M,
    input  logic [AW-1:0] wa3W,
    input  logic          regWriteM,
    input  logic          regWriteW,
    output fwd_sel_t      fwdSel
);
    logic notPc;
    assign notPc = (rsE != AW'(PC_REG));

    always_comb begin
        fwdSel = FWD_RF;
        if (regWriteM && (wa3M == rsE) && notPc)
            fwdSel = FWD_M;
        else if (regWriteW && (wa3W == rsE) && notPc)
            fwdSel = FWD_W;
    end
endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit with forwarding, load-use, control, memory-wait and multiply stalls.
// Optional HAZARD_PERF_EN adds 32-bit stall/flush/mem-wait cycle counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int AW          = 4,
    parameter int PC_REG      = 15,
    parameter int MUL_CYCLES  = 3,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    hazard_unit_mc_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       PerfStallCyc,
    output logic [31:0]       PerfFlushCyc,
    output logic [31:0]       PerfMemWaitCyc
`endif
);
    localparam int MCW = ($clog2(MUL_CYCLES) < 1) ? 1 : $clog2(MUL_CYCLES);
    localparam int WCW = waitCntW(MEM_TIMEOUT);
    localparam logic [MCW-1:0] MUL_LOAD  = MCW'(MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    // Forwarding: one comparator lane per Execute operand (0 = A, 1 = B).
    logic [1:0][AW-1:0] rsE;
    fwd_sel_t [1:0]     fwdSel;
    assign rsE = {hz.RA2E, hz.RA1E};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        hazard_fwd_sel #(.AW(AW), .PC_REG(PC_REG)) u_fwd (
            .rsE       (rsE[i]),
            .wa3M      (hz.WA3M),
            .wa3W      (hz.WA3W),
            .regWriteM (hz.RegWriteM),
            .regWriteW (hz.RegWriteW),
            .fwdSel    (fwdSel[i])
        );
    end

    logic memWait;
    assign memWait = hz.MemReqM & ~hz.MemReadyM;

    // Multiply occupancy FSM
    mul_state_t     state, stateNxt;
    logic [MCW-1:0] mulCnt, mulCntNxt;
    logic           mulBusy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mulCnt <= '0;
        end else begin
            state  <= stateNxt;
            mulCnt <= mulCntNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        mulCntNxt = mulCnt;
        case (state)
            IDLE: if (hz.MulStartE && !memWait && (MUL_CYCLES > 1)) begin
                stateNxt  = BUSY;
                mulCntNxt = MUL_LOAD;
            end
            BUSY: if (!memWait) begin
                if (mulCnt == '0) stateNxt  = IDLE;
                else              mulCntNxt = mulCnt - MCW'(1);
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign mulBusy = (state == BUSY);

    // Memory watchdog: counter saturates at the trip point; the flag is sticky.
    logic [WCW-1:0] waitCnt;
    logic           toSticky, toHit;
    assign toHit = memWait && (waitCnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt  <= '0;
            toSticky <= 1'b0;
        end else begin
            if (!memWait)                 waitCnt <= '0;
            else if (waitCnt != WAIT_LAST) waitCnt <= waitCnt + WCW'(1);
            if (toHit) toSticky <= 1'b1;
        end
    end

    // Stall/flush resolution; a frozen pipe overrides every flush.
    logic ldStall, pcWrPending;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;

    assign ldStall     = hz.MemtoRegE & ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
    assign pcWrPending = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;

    assign flushD = ~memWait & (pcWrPending | hz.PCSrcW | hz.BranchTakenE);
    assign flushE = ~memWait & ~mulBusy & (ldStall | hz.BranchTakenE);
    assign flushM = ~memWait & mulBusy;
    assign flushW = memWait;
    assign stallF = memWait | mulBusy | ldStall | pcWrPending;
    assign stallD = (memWait | mulBusy | ldStall) & ~flushD;
    assign stallE = memWait | mulBusy;
    assign stallM = memWait;

    // Every output is held low while reset is asserted.
    assign hz.ForwardAE  = reset ? fwdSel[0] : FWD_RF;
    assign hz.ForwardBE  = reset ? fwdSel[1] : FWD_RF;
    assign hz.StallF     = reset & stallF;
    assign hz.StallD     = reset & stallD;
    assign hz.StallE     = reset & stallE;
    assign hz.StallM     = reset & stallM;
    assign hz.FlushD     = reset & flushD;
    assign hz.FlushE     = reset & flushE;
    assign hz.FlushM     = reset & flushM;
    assign hz.FlushW     = reset & flushW;
    assign hz.MulBusy    = reset & mulBusy;
    assign hz.MemTimeout = reset & (toSticky | toHit);

    illegalBrMul: assert property (@(posedge clk) disable iff (!reset)
        !(hz.BranchTakenE && hz.MulStartE));

`ifdef HAZARD_PERF_EN
    logic anyFlush;
    assign anyFlush = hz.FlushD | hz.FlushE | hz.FlushM | hz.FlushW;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PerfStallCyc   <= '0;
            PerfFlushCyc   <= '0;
            PerfMemWaitCyc <= '0;
        end else begin
            if (hz.StallF) PerfStallCyc   <= PerfStallCyc + 32'd1;
            if (anyFlush)  PerfFlushCyc   <= PerfFlushCyc + 32'd1;
            if (memWait)   PerfMemWaitCyc <= PerfMemWaitCyc + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MUL_CYCLES=3, MEM_TIMEOUT=4).
module tb_hazard_unit_mc;
    logic clk = 1'b0;
    logic reset;
    int   nCmp = 0;
    int   nBad = 0;

    hazard_unit_mc_if #(.AW(4)) hif();

`ifdef HAZARD_PERF_EN
    logic [31:0] perfS, perfF, perfM;
`endif

    hazard_unit_mc #(.AW(4), .PC_REG(15), .MUL_CYCLES(3), .MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
`ifdef HAZARD_PERF_EN
        ,
        .PerfStallCyc   (perfS),
        .PerfFlushCyc   (perfF),
        .PerfMemWaitCyc (perfM)
`endif
    );

    always #5 clk = ~clk;

    // Observed vector: {FwdA, FwdB, StallF D E M, FlushD E M W, MulBusy, MemTimeout}
    localparam logic [13:0] Z     = 14'b00_00_0000_0000_00;
    localparam logic [13:0] BUSYV = 14'b00_00_1110_0010_10;
    localparam logic [13:0] MEMW  = 14'b00_00_1111_0001_00;
    localparam logic [13:0] TO    = 14'b00_00_0000_0000_01;
    localparam logic [13:0] LDU   = 14'b00_00_1100_0100_00;
    localparam logic [13:0] BR    = 14'b00_00_0000_1100_00;
    localparam logic [13:0] PCD   = 14'b00_00_1000_1000_00;
    localparam logic [13:0] CONF  = 14'b00_00_1000_1100_00;

    task automatic clr();
        hif.RA1D = '0; hif.RA2D = '0; hif.RA1E = '0; hif.RA2E = '0;
        hif.WA3E = '0; hif.WA3M = '0; hif.WA3W = '0;
        hif.RegWriteM = 0; hif.RegWriteW = 0; hif.MemtoRegE = 0;
        hif.PCSrcD = 0; hif.PCSrcE = 0; hif.PCSrcM = 0; hif.PCSrcW = 0;
        hif.BranchTakenE = 0; hif.MulStartE = 0;
        hif.MemReqM = 0; hif.MemReadyM = 0;
    endtask

    task automatic chkNow(input string tag, input logic [13:0] e);
        logic [13:0] o;
        o = {hif.ForwardAE, hif.ForwardBE,
             hif.StallF, hif.StallD, hif.StallE, hif.StallM,
             hif.FlushD, hif.FlushE, hif.FlushM, hif.FlushW,
             hif.MulBusy, hif.MemTimeout};
        nCmp++;
        assert (o === e) else begin
            nBad++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic chk(input string tag, input logic [13:0] e);
        @(negedge clk);
        chkNow(tag, e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with hazard-provoking inputs: everything must stay low.
        clr();
        reset = 1'b0;
        hif.MemReqM = 1; hif.RegWriteM = 1; hif.WA3M = 4'd3; hif.RA1E = 4'd3;
        hif.MemtoRegE = 1; hif.WA3E = 4'd5; hif.RA2D = 4'd5; hif.MulStartE = 1;
        chk("reset_outputs", Z);
        cyc();
        clr();
        reset = 1'b1;

        // Forwarding
        hif.RegWriteM = 1; hif.WA3M = 4'd3; hif.RegWriteW = 1; hif.WA3W = 4'd3; hif.RA1E = 4'd3;
        chk("fwd_m_priority", 14'b10_00_0000_0000_00);
        cyc();
        hif.WA3M = 4'd15; hif.RA1E = 4'd15; hif.RA2E = 4'd3;
        chk("fwd_pc_never", 14'b00_01_0000_0000_00);
        cyc();
        hif.RegWriteM = 0; hif.WA3M = 4'd3; hif.RA1E = 4'd3; hif.RA2E = 4'd4;
        chk("fwd_w_only", 14'b01_00_0000_0000_00);
        cyc();

        // Load-use then clear
        clr();
        hif.MemtoRegE = 1; hif.WA3E = 4'd5; hif.RA2D = 4'd5;
        chk("load_use", LDU);
        cyc();
        hif.MemtoRegE = 0;
        chk("load_use_clear", Z);
        cyc();

        // Control hazards
        clr();
        hif.BranchTakenE = 1;
        chk("branch_taken", BR);
        cyc();
        clr();
        hif.PCSrcD = 1;
        chk("pcsrc_d", PCD);
        cyc();
        clr();
        hif.MemtoRegE = 1; hif.WA3E = 4'd5; hif.RA1D = 4'd5; hif.PCSrcE = 1;
        chk("flushd_beats_stalld", CONF);
        cyc();

        // Multiply: 2 BUSY cycles, MulStartE ignored while BUSY, load-use FlushE gated
        clr();
        hif.MulStartE = 1;
        chk("mul_start", Z);
        cyc();
        chk("mul_busy1", BUSYV);
        cyc();
        hif.MulStartE = 0;
        hif.MemtoRegE = 1; hif.WA3E = 4'd5; hif.RA1D = 4'd5;
        chk("mul_busy2_ldu", BUSYV);
        cyc();
        clr();
        chk("mul_done", Z);
        cyc();

        // Multiply extended by 2 memory-wait cycles
        hif.MulStartE = 1;
        chk("mulw_start", Z);
        cyc();
        hif.MulStartE = 0;
        chk("mulw_busy1", BUSYV);
        cyc();
        hif.MemReqM = 1;
        chk("mulw_wait1", MEMW | 14'b00_00_0000_0000_10);
        cyc();
        chk("mulw_wait2", MEMW | 14'b00_00_0000_0000_10);
        cyc();
        hif.MemReqM = 0;
        chk("mulw_busy2", BUSYV);
        cyc();
        chk("mulw_done", Z);
        cyc();

        // Reset mid-multiply aborts, then a full occupancy restarts
        hif.MulStartE = 1;
        chk("mulr_start", Z);
        cyc();
        hif.MulStartE = 0;
        chk("mulr_busy", BUSYV);
        #1 reset = 1'b0;
        #1 chkNow("mulr_reset_abort", Z);
        cyc();
        reset = 1'b1;
        hif.MulStartE = 1;
        chk("mulr_restart", Z);
        cyc();
        hif.MulStartE = 0;
        chk("mulr_busy_a", BUSYV);
        cyc();
        chk("mulr_busy_b", BUSYV);
        cyc();
        chk("mulr_done", Z);
        cyc();

        // Memory wait 4 cycles with concurrent branch/PC writes
        clr();
        hif.MemReqM = 1; hif.BranchTakenE = 1; hif.PCSrcW = 1; hif.PCSrcD = 1;
        chk("memw_1_branch", MEMW);
        cyc();
        hif.BranchTakenE = 0; hif.PCSrcW = 0; hif.PCSrcD = 0;
        chk("memw_2", MEMW);
        cyc();
        chk("memw_3", MEMW);
        cyc();
        chk("memw_4_timeout", MEMW | TO);
        cyc();
        hif.MemReadyM = 1;
        chk("memw_ready", TO);
        cyc();

        // Reset clears the sticky flag, then a 10-cycle wait
        clr();
        reset = 1'b0;
        chk("to_reset", Z);
        cyc();
        reset = 1'b1;
        hif.MemReqM = 1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("to_wait%0d", i + 1), (i >= 3) ? (MEMW | TO) : MEMW);
            cyc();
        end
        hif.MemReqM = 0;
        chk("to_sticky", TO);
        cyc();
        reset = 1'b0;
        chk("to_cleared_in_reset", Z);
        cyc();
        reset = 1'b1;
        chk("to_cleared_after", Z);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the pipeline hazard unit of the 5-stage ARM core.
- Performs its own register-address comparisons, so the datapath no longer supplies pre-computed match bits.
- Adds two stall sources the previous unit lacks:
  - variable-latency data memory, via a MemReq/MemReady handshake with a watchdog;
  - multi-cycle multiply occupancy in the Execute stage.
- Sits beside controller and datapath; drives forwarding selects plus stall/flush for F, D, E, M, W.

Parameters:
- AW, 4, register address width (2**AW architectural registers).
- PC_REG, 15, register index that is never forwarded (PC).
- MUL_CYCLES, 3, total Execute-stage cycles for a multiply (>=1).
- MEM_TIMEOUT, 64, wait cycles before MemTimeout is set (>=2).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- RA1D, RA2D  in  AW  Decode source registers.
- RA1E, RA2E  in  AW  Execute source registers.
- WA3E, WA3M, WA3W  in  AW  destination register per stage.
- RegWriteM, RegWriteW, MemtoRegE  in  1  control bits per stage.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-write flags per stage.
- BranchTakenE  in  1  branch resolved taken in E.
- MulStartE  in  1  multiply present in E.
- MemReqM  in  1  M stage has a memory access.
- MemReadyM  in  1  memory completes this cycle.
- ForwardAE, ForwardBE  out  2  00 register file, 01 from W, 10 from M.
- StallF, StallD, StallE, StallM  out  1  hold the stage register.
- FlushD, FlushE, FlushM, FlushW  out  1  insert a bubble into the stage register.
- MulBusy  out  1  multiply FSM is in BUSY.
- MemTimeout  out  1  sticky watchdog flag.

Behaviour:
- Reset:
  - While reset=0, all outputs are 0.
  - Multiply FSM goes to IDLE; both counters clear; MemTimeout clears.
  - Asserting reset mid-multiply or mid-wait aborts it immediately.
- Forwarding (combinational), operand A; operand B is identical using RA2E:
  - 10 if RegWriteM & WA3M==RA1E & RA1E!=PC_REG.
  - else 01 if RegWriteW & WA3W==RA1E & RA1E!=PC_REG.
  - else 00.
  - M has priority over W.
- MemWait = MemReqM & ~MemReadyM:
  - asserts StallF, StallD, StallE, StallM and FlushW;
  - forces FlushD, FlushE, FlushM to 0 (a frozen pipe wins over every flush).
- Wait counter:
  - increments each cycle MemWait=1 and clears when MemWait=0;
  - when it reaches MEM_TIMEOUT-1 while MemWait=1, MemTimeout sets and stays set until reset;
  - pipeline behaviour is unchanged by the timeout.
- Multiply FSM, states IDLE and BUSY:
  - IDLE -> BUSY when MulStartE & ~MemWait & MUL_CYCLES>1; count is loaded with MUL_CYCLES-2.
  - In BUSY: StallF, StallD, StallE and FlushM assert, and MulBusy=1.
  - Count decrements only when ~MemWait.
  - BUSY -> IDLE when count==0 & ~MemWait.
  - The cycle after leaving BUSY, E advances normally; total E occupancy is exactly MUL_CYCLES.
  - MUL_CYCLES=1: the FSM never leaves IDLE.
  - MulStartE is sampled only in IDLE.
- Load-use:
  - LdStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
  - Asserts StallF and StallD.
  - Asserts FlushE unless MulBusy or MemWait.
- Control hazards (suppressed under MemWait):
  - PCWrPendingF = PCSrcD|PCSrcE|PCSrcM; it asserts StallF.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = LdStall | BranchTakenE, both gated by ~MulBusy.
- Conflicts:
  - If StallD and FlushD are both active, FlushD wins, except under MemWait.
  - BranchTakenE & MulStartE in the same cycle is illegal; this is checked by assertion.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - adds 32-bit output ports PerfStallCyc, PerfFlushCyc, PerfMemWaitCyc;
  - they count cycles with StallF=1, with any flush output=1, and with MemWait=1;
  - they wrap at 2**32 and clear on reset.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - mul_state_t enum: IDLE, BUSY;
  - width helper for the wait counter, $clog2(MEM_TIMEOUT)+1.
- One sub-module, hazard_fwd_sel: a single-operand comparator/priority encoder, instantiated for A and B.

Test Plan:
- WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1, RA1E=3 -> ForwardAE=10. Same with RA1E=15 -> ForwardAE=00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> one cycle of StallF=StallD=FlushE=1. Next cycle with MemtoRegE=0 -> all 0.
- MemReqM=1, MemReadyM held low 4 cycles -> StallF/D/E/M=1 and FlushW=1 for exactly 4 cycles; a concurrent BranchTakenE gives FlushD=FlushE=0.
- MUL_CYCLES=3, MulStartE pulse -> MulBusy=1 and FlushM=1 for 2 cycles, then E advances. MemWait for 2 cycles during BUSY -> BUSY extends by 2.
- MEM_TIMEOUT=4, MemWait held 10 cycles -> MemTimeout rises on the 4th wait cycle and stays 1 until reset=0.
- Reset asserted while BUSY with count=1 -> MulBusy=0 immediately; after release, MulStartE restarts a full MUL_CYCLES occupancy.
